// File: rtl/spi_slave_ram_if.sv
// rtl/spi_slave_ram_if.sv - SPI slave framing MOSI into {cmd,payload} words and serialising RAM read data on MISO
module spi_slave_ram_if #(
  parameter int   DATA_W     = 8,
  parameter int   TX_TIMEOUT = 16,
  parameter logic MISO_IDLE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              rd_pending
);

  localparam int W  = DATA_W + 2;
  localparam int CW = $clog2(W + 1);
  localparam int TW = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      frame_sr, frame_sr_nxt;
  logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [TW-1:0]     to_cnt, to_cnt_nxt;
  logic              miso_nxt;
  logic [W-1:0]      rx_data_nxt;
  logic              rx_valid_nxt, frame_err_nxt, rd_pending_nxt;
  logic              cmd_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_sr   <= '0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      MISO       <= MISO_IDLE;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_sr   <= frame_sr_nxt;
      tx_sr      <= tx_sr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      MISO       <= miso_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      frame_err  <= frame_err_nxt;
      rd_pending <= rd_pending_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    frame_sr_nxt   = frame_sr;
    tx_sr_nxt      = tx_sr;
    bit_cnt_nxt    = bit_cnt;
    to_cnt_nxt     = to_cnt;
    miso_nxt       = MISO;
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = 1'b0;
    frame_err_nxt  = 1'b0;
    rd_pending_nxt = rd_pending;
    cmd_ok         = 1'b0;

    if (SS_n) begin
      // Deselect aborts everything; only a frame already finished in DONE is clean.
      if (state != IDLE) begin
        state_nxt     = IDLE;
        bit_cnt_nxt   = '0;
        to_cnt_nxt    = '0;
        miso_nxt      = MISO_IDLE;
        frame_err_nxt = (state != DONE);
      end
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = CHK_CMD;
          bit_cnt_nxt = '0;
          to_cnt_nxt  = '0;
          miso_nxt    = MISO_IDLE;
        end
        CHK_CMD: begin
          frame_sr_nxt = {frame_sr[W-2:0], MOSI};
          bit_cnt_nxt  = CW'(1);
          if (!MOSI)          state_nxt = WRITE;
          else if (rd_pending) state_nxt = READ_DATA;
          else                 state_nxt = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt != CW'(W)) begin
            frame_sr_nxt = {frame_sr[W-2:0], MOSI};
            bit_cnt_nxt  = bit_cnt + CW'(1);
          end else begin
            cmd_ok = (state == WRITE) ||
                     (state == READ_ADD  && frame_sr[W-1:W-2] == 2'b10) ||
                     (state == READ_DATA && frame_sr[W-1:W-2] == 2'b11);
            bit_cnt_nxt = '0;
            to_cnt_nxt  = '0;
            if (cmd_ok) begin
              rx_valid_nxt = 1'b1;
              rx_data_nxt  = frame_sr;
              if (state == READ_ADD) rd_pending_nxt = 1'b1;
              state_nxt = (state == READ_DATA) ? TX_WAIT : DONE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = DONE;
            end
          end
        end
        TX_WAIT: begin
          if (tx_valid) begin
            tx_sr_nxt   = tx_data;
            bit_cnt_nxt = '0;
            to_cnt_nxt  = '0;
            state_nxt   = TX_SHIFT;
          end else if (TX_TIMEOUT != 0) begin
            to_cnt_nxt = to_cnt + TW'(1);
            if (to_cnt_nxt == TW'(TX_TIMEOUT)) begin
              frame_err_nxt  = 1'b1;
              rd_pending_nxt = 1'b0;
              state_nxt      = DONE;
            end
          end
        end
        TX_SHIFT: begin
          if (bit_cnt != CW'(DATA_W)) begin
            miso_nxt    = tx_sr[DATA_W-1];
            tx_sr_nxt   = tx_sr << 1;
            bit_cnt_nxt = bit_cnt + CW'(1);
          end else begin
            miso_nxt       = MISO_IDLE;
            rd_pending_nxt = 1'b0;
            bit_cnt_nxt    = '0;
            state_nxt      = DONE;
          end
        end
        DONE: begin
          miso_nxt = MISO_IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// tb/tb_spi_slave_ram_if.sv - directed self-checking bench for spi_slave_ram_if (DATA_W=8, TX_TIMEOUT=16)
module tb_spi_slave_ram_if;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, tx_valid;
  logic [7:0] tx_data;
  logic       MISO, rx_valid, frame_err, rd_pending;
  logic [9:0] rx_data;
  int         total = 0;
  int         bad = 0;

  spi_slave_ram_if #(.DATA_W(8), .TX_TIMEOUT(16), .MISO_IDLE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err), .rd_pending(rd_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives select plus all W frame bits; the evaluation edge is left to the caller.
  task automatic send_bits(input logic [9:0] f);
    logic [9:0] fr;
    fr = f;
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = fr[i];
      tick();
      chk("cap_rxv", {15'd0, rx_valid}, 16'd0);
      chk("cap_err", {15'd0, frame_err}, 16'd0);
    end
    MOSI = 1'b0;
  endtask

  task automatic deselect(input logic exp_err);
    SS_n = 1'b1;
    tick();
    chk("desel_err", {15'd0, frame_err}, {15'd0, exp_err});
    tick();
    chk("idle_err", {15'd0, frame_err}, 16'd0);
  endtask

  initial begin
    logic [7:0] txv;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(); tick();
    chk("rst_miso", {15'd0, MISO}, 16'd0);
    chk("rst_rxd", {6'd0, rx_data}, 16'h000);
    chk("rst_rxv", {15'd0, rx_valid}, 16'd0);
    chk("rst_err", {15'd0, frame_err}, 16'd0);
    chk("rst_pend", {15'd0, rd_pending}, 16'd0);
    rst_n = 1'b1;
    tick();

    // 1: write frame 00_1010_0101
    send_bits(10'b00_1010_0101);
    tick();
    chk("t1_rxv", {15'd0, rx_valid}, 16'd1);
    chk("t1_rxd", {6'd0, rx_data}, 16'h0A5);
    chk("t1_pend", {15'd0, rd_pending}, 16'd0);
    chk("t1_err", {15'd0, frame_err}, 16'd0);
    tick();
    chk("t1_rxv_off", {15'd0, rx_valid}, 16'd0);
    deselect(1'b0);

    // 2: read address then read data with C3 returned
    send_bits(10'b10_0011_1100);
    tick();
    chk("t2a_rxv", {15'd0, rx_valid}, 16'd1);
    chk("t2a_rxd", {6'd0, rx_data}, 16'h23C);
    chk("t2a_pend", {15'd0, rd_pending}, 16'd1);
    deselect(1'b0);
    send_bits(10'b11_0101_0101);
    tick();
    chk("t2b_rxv", {15'd0, rx_valid}, 16'd1);
    chk("t2b_rxd", {6'd0, rx_data}, 16'h355);
    tick();
    chk("t2_wait_miso", {15'd0, MISO}, 16'd0);
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick();
    chk("t2_latch_miso", {15'd0, MISO}, 16'd0);
    tx_valid = 1'b0; tx_data = 8'h00;
    txv = 8'b1100_0011;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk("t2_miso_bit", {15'd0, MISO}, {15'd0, txv[i]});
      chk("t2_pend_shift", {15'd0, rd_pending}, 16'd1);
    end
    tick();
    chk("t2_miso_idle", {15'd0, MISO}, 16'd0);
    chk("t2_pend_clr", {15'd0, rd_pending}, 16'd0);
    deselect(1'b0);

    // 3: abort a write after five bits
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      tick();
    end
    MOSI = 1'b0;
    SS_n = 1'b1;
    tick();
    chk("t3_err", {15'd0, frame_err}, 16'd1);
    chk("t3_rxv", {15'd0, rx_valid}, 16'd0);
    chk("t3_rxd", {6'd0, rx_data}, 16'h355);
    tick();
    chk("t3_err_off", {15'd0, frame_err}, 16'd0);

    // 4: read-data timeout after 16 cycles
    send_bits(10'b10_0000_0001);
    tick();
    chk("t4_pend", {15'd0, rd_pending}, 16'd1);
    deselect(1'b0);
    send_bits(10'b11_0000_0001);
    tick();
    chk("t4_rxd", {6'd0, rx_data}, 16'h301);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t4_wait_err", {15'd0, frame_err}, 16'd0);
    end
    tick();
    chk("t4_to_err", {15'd0, frame_err}, 16'd1);
    chk("t4_to_pend", {15'd0, rd_pending}, 16'd0);
    chk("t4_to_miso", {15'd0, MISO}, 16'd0);
    tick();
    chk("t4_err_off", {15'd0, frame_err}, 16'd0);
    deselect(1'b0);

    // 5: malformed read-address (cmd 11 with nothing pending)
    send_bits(10'b11_1111_0000);
    tick();
    chk("t5_err", {15'd0, frame_err}, 16'd1);
    chk("t5_rxv", {15'd0, rx_valid}, 16'd0);
    chk("t5_rxd", {6'd0, rx_data}, 16'h301);
    chk("t5_pend", {15'd0, rd_pending}, 16'd0);
    deselect(1'b0);

    // abort in TX_WAIT keeps the read pending
    send_bits(10'b10_1000_0000);
    tick();
    deselect(1'b0);
    send_bits(10'b11_1000_0000);
    tick();
    tick();
    SS_n = 1'b1;
    tick();
    chk("txw_abort_err", {15'd0, frame_err}, 16'd1);
    chk("txw_abort_pend", {15'd0, rd_pending}, 16'd1);
    tick();

    // 6: retry, then reset in the middle of TX_SHIFT
    send_bits(10'b11_1000_0000);
    tick();
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick(); tick(); tick();
    chk("t6_pre_miso", {15'd0, MISO}, 16'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_miso", {15'd0, MISO}, 16'd0);
    chk("t6_rst_rxd", {6'd0, rx_data}, 16'h000);
    chk("t6_rst_pend", {15'd0, rd_pending}, 16'd0);
    chk("t6_rst_err", {15'd0, frame_err}, 16'd0);
    chk("t6_rst_rxv", {15'd0, rx_valid}, 16'd0);
    rst_n = 1'b1; SS_n = 1'b1;
    tick();
    send_bits(10'b01_1111_1111);
    tick();
    chk("t6_wr_rxv", {15'd0, rx_valid}, 16'd1);
    chk("t6_wr_rxd", {6'd0, rx_data}, 16'h1FF);
    chk("t6_wr_pend", {15'd0, rd_pending}, 16'd0);
    deselect(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
